// File: rtl/uart_dump.sv
`default_nettype none
// ============================================================================
// Module   : uart_dump
// Purpose  : Debug readback engine. On a start pulse it reads a contiguous
//            block of 32-bit words through the RIB master-1 read port and
//            sends each word over a UART TX line as four 8N1 frames,
//            least-significant byte first.
// Ports    : clk_i, rst_n_i        - clock, asynchronous active-low reset
//            dump_en_i             - level enable; low aborts to idle
//            start_i               - one-cycle start pulse (idle only)
//            start_addr_i          - first byte address (bits [1:0] ignored)
//            word_cnt_i            - number of words to dump
//            rib_rreq_o            - bus read request
//            mem_raddr_o           - bus read address
//            mem_rdata_i           - bus read data (combinational)
//            rib_hold_i            - arbitration hold, read not granted
//            uart_tx_o             - serial output, idle high
//            busy_o                - dump in progress
//            done_o                - one-cycle pulse on normal completion
// Revision : 1.0 - initial release
// ============================================================================
module uart_dump #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             dump_en_i,
  input  logic             start_i,
  input  logic [31:0]      start_addr_i,
  input  logic [CNT_W-1:0] word_cnt_i,
  output logic             rib_rreq_o,
  output logic [31:0]      mem_raddr_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             rib_hold_i,
  output logic             uart_tx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned       BAUD_W    = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_TX   = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q,     state_d;
  logic [31:0]        addr_q,      addr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [31:0]        word_q,      word_d;
  logic [1:0]         byte_idx_q,  byte_idx_d;
  logic [BAUD_W-1:0]  baud_cnt_q,  baud_cnt_d;
  logic [3:0]         bit_cnt_q,   bit_cnt_d;
  logic               tx_q,        tx_d;
  logic               rreq_q,      rreq_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic [9:0]         frame_w;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && dump_en_i) begin
          addr_d      = start_addr_i & ~32'h3;
          remaining_d = word_cnt_i;
          busy_d      = 1'b1;
          state_d     = (word_cnt_i == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (!rib_hold_i) begin
          word_d     = mem_rdata_i;
          byte_idx_d = 2'd0;
          baud_cnt_d = '0;
          bit_cnt_d  = 4'd0;
          state_d    = S_TX;
        end
      end
      S_TX: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
            if (byte_idx_q == 2'd3) begin
              state_d = S_NEXT;
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      S_NEXT: begin
        addr_d      = addr_q + 32'd4;
        remaining_d = remaining_q - CNT_W'(1);
        state_d     = (remaining_q == CNT_W'(1)) ? S_DONE : S_READ;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides any transition; a frame in flight is simply cut off.
    if (!dump_en_i && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      baud_cnt_d = '0;
      bit_cnt_d  = 4'd0;
    end

    // Outputs are registered: derive them from the next-cycle state so they
    // line up exactly with the state they describe.
    frame_w = {1'b1, word_d[{byte_idx_d, 3'b000} +: 8], 1'b0};
    tx_d    = (state_d == S_TX) ? frame_w[bit_cnt_d] : 1'b1;
    rreq_d  = (state_d == S_READ);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
      rreq_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rreq_q      <= rreq_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The address register is only written in IDLE and NEXT, so it is stable
  // throughout READ and can drive the bus directly.
  assign mem_raddr_o = addr_q;
  assign rib_rreq_o  = rreq_q;
  assign uart_tx_o   = tx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_dump
// Purpose  : Directed self-checking bench for uart_dump with BAUD_DIV=4.
//            A small UART receiver decodes the serial line; read addresses
//            and done pulses are logged and compared against hand-computed
//            values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_dump;

  localparam int BD = 4;

  logic        clk;
  logic        rst_n_i;
  logic        dump_en_i;
  logic        start_i;
  logic [31:0] start_addr_i;
  logic [15:0] word_cnt_i;
  logic        rib_rreq_o;
  logic [31:0] mem_raddr_o;
  logic [31:0] mem_rdata_i;
  logic        rib_hold_i;
  logic        uart_tx_o;
  logic        busy_o;
  logic        done_o;

  uart_dump #(.BAUD_DIV(BD), .CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .dump_en_i    (dump_en_i),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .word_cnt_i   (word_cnt_i),
    .rib_rreq_o   (rib_rreq_o),
    .mem_raddr_o  (mem_raddr_o),
    .mem_rdata_i  (mem_rdata_i),
    .rib_hold_i   (rib_hold_i),
    .uart_tx_o    (uart_tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model; garbage while held so a capture during hold shows up.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h1000_0000: return 32'h1234_5678;
      32'h1000_0004: return 32'hA1B2_C3D4;
      32'h1000_0008: return 32'h0F1E_2D3C;
      32'hFFFF_FFFC: return 32'hCAFE_BABE;
      32'h0000_0000: return 32'h0102_0304;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction
  assign mem_rdata_i = rib_hold_i ? 32'hBAD0_BAD0 : mem_word(mem_raddr_o);

  // Logs of bus activity and done pulses (pre-edge values).
  logic [31:0] rd_q[$];
  int          rreq_cycles;
  int          done_cnt;
  always @(posedge clk) begin
    if (rib_rreq_o) rreq_cycles++;
    if (rib_rreq_o && !rib_hold_i) rd_q.push_back(mem_raddr_o);
    if (done_o) done_cnt++;
  end

  // UART receiver: samples mid-bit on the falling clock edge.
  logic [7:0] bytes[$];
  logic       dec_flush;
  logic       dact;
  logic [7:0] dsh;
  int         dc;
  int         ferr;
  always @(negedge clk) begin
    int k;
    if (dec_flush || !rst_n_i) begin
      dact = 1'b0;
      dc   = 0;
    end else if (!dact) begin
      if (uart_tx_o === 1'b0) begin
        dact = 1'b1;
        dc   = 0;
      end
    end else begin
      dc++;
      if ((dc % BD) == (BD / 2)) begin
        k = dc / BD;
        if (k == 0) begin
          if (uart_tx_o !== 1'b0) begin
            ferr++;
            dact = 1'b0;
          end
        end else if (k <= 8) begin
          dsh[k-1] = uart_tx_o;
        end else begin
          if (uart_tx_o === 1'b1) bytes.push_back(dsh);
          else ferr++;
          dact = 1'b0;
        end
      end
    end
  end

  int total;
  int passed;
  int fail_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_q.delete();
    bytes.delete();
    rreq_cycles = 0;
    done_cnt    = 0;
    ferr        = 0;
  endtask

  // Returns at #1 after the edge that samples start_i.
  task automatic do_start(input logic [31:0] a, input logic [15:0] n);
    start_addr_i = a;
    word_cnt_i   = n;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done_o && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_word(input int idx, input logic [31:0] w);
    logic [31:0] obs;
    for (int b = 0; b < 4; b++) begin
      obs = (4 * idx + b < bytes.size()) ? {24'h0, bytes[4 * idx + b]} : 32'hFFFF_FFFF;
      chk($sformatf("byte%0d", 4 * idx + b), obs, {24'h0, w[8 * b +: 8]});
    end
  endtask

  task automatic chk_rd(input int idx, input logic [31:0] a);
    logic [31:0] obs;
    obs = (idx < rd_q.size()) ? rd_q[idx] : 32'hXXXX_XXXX;
    chk($sformatf("read_addr%0d", idx), obs, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int good;
    int tx_low;
    total = 0; passed = 0; fail_cnt = 0;
    rst_n_i = 1'b0; dump_en_i = 1'b1; start_i = 1'b0; rib_hold_i = 1'b0;
    start_addr_i = '0; word_cnt_i = '0; dec_flush = 1'b0;
    clear_logs();
    repeat (3) tick();

    // Reset state
    chk("rst_tx",    {31'h0, uart_tx_o},  32'h1);
    chk("rst_busy",  {31'h0, busy_o},     32'h0);
    chk("rst_rreq",  {31'h0, rib_rreq_o}, 32'h0);
    chk("rst_raddr", mem_raddr_o,         32'h0);
    chk("rst_done",  {31'h0, done_o},     32'h0);
    rst_n_i = 1'b1;
    tick();

    // Reset asserted during a start bit
    do_start(32'h1000_0000, 16'd1);
    tick();
    chk("pre_rst_tx", {31'h0, uart_tx_o}, 32'h0);
    #1 rst_n_i = 1'b0;
    #1;
    chk("mid_rst_tx",   {31'h0, uart_tx_o},  32'h1);
    chk("mid_rst_busy", {31'h0, busy_o},     32'h0);
    chk("mid_rst_rreq", {31'h0, rib_rreq_o}, 32'h0);
    repeat (2) tick();
    rst_n_i = 1'b1;
    tick();

    // Single word
    clear_logs();
    do_start(32'h1000_0000, 16'd1);
    chk("w1_busy",  {31'h0, busy_o},     32'h1);
    chk("w1_rreq",  {31'h0, rib_rreq_o}, 32'h1);
    chk("w1_raddr", mem_raddr_o,         32'h1000_0000);
    chk("w1_tx_idle", {31'h0, uart_tx_o}, 32'h1);
    tick();
    chk("w1_start_bit", {31'h0, uart_tx_o}, 32'h0);
    wait_done(400, n);
    chk("w1_latency", n, 32'd161);
    tick();
    chk("w1_done_low", {31'h0, done_o}, 32'h0);
    chk("w1_busy_low", {31'h0, busy_o}, 32'h0);
    chk("w1_done_cnt", done_cnt, 32'd1);
    chk("w1_nreads", rd_q.size(), 32'd1);
    chk_rd(0, 32'h1000_0000);
    chk("w1_nbytes", bytes.size(), 32'd4);
    chk_word(0, 32'h1234_5678);
    chk("w1_ferr", ferr, 32'd0);

    // Three words, unaligned start, start pulse while busy
    clear_logs();
    do_start(32'h1000_0003, 16'd3);
    repeat (20) tick();
    start_addr_i = 32'h2000_0000;
    word_cnt_i   = 16'd5;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
    wait_done(2000, n);
    chk("w3_latency", n, 32'd465);
    tick();
    chk("w3_nreads", rd_q.size(), 32'd3);
    chk_rd(0, 32'h1000_0000);
    chk_rd(1, 32'h1000_0004);
    chk_rd(2, 32'h1000_0008);
    chk("w3_nbytes", bytes.size(), 32'd12);
    chk_word(0, 32'h1234_5678);
    chk_word(1, 32'hA1B2_C3D4);
    chk_word(2, 32'h0F1E_2D3C);
    chk("w3_done_cnt", done_cnt, 32'd1);
    chk("w3_ferr", ferr, 32'd0);

    // Zero word count
    clear_logs();
    do_start(32'h1000_0000, 16'd0);
    chk("w0_done", {31'h0, done_o}, 32'h1);
    chk("w0_busy", {31'h0, busy_o}, 32'h1);
    tx_low = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (uart_tx_o !== 1'b1) tx_low++;
    end
    chk("w0_tx_high", tx_low, 32'd0);
    chk("w0_busy_low", {31'h0, busy_o}, 32'h0);
    chk("w0_rreq_cycles", rreq_cycles, 32'd0);
    chk("w0_done_cnt", done_cnt, 32'd1);
    chk("w0_nbytes", bytes.size(), 32'd0);

    // Arbitration hold for 7 cycles
    clear_logs();
    rib_hold_i = 1'b1;
    do_start(32'h1000_0004, 16'd1);
    good = 0;
    for (int i = 0; i < 7; i++) begin
      if (rib_rreq_o === 1'b1 && mem_raddr_o === 32'h1000_0004) good++;
      tick();
    end
    rib_hold_i = 1'b0;
    if (rib_rreq_o === 1'b1 && mem_raddr_o === 32'h1000_0004) good++;
    chk("hold_stable", good, 32'd8);
    tick();
    chk("hold_rreq_off", {31'h0, rib_rreq_o}, 32'h0);
    chk("hold_start_bit", {31'h0, uart_tx_o}, 32'h0);
    wait_done(400, n);
    chk("hold_latency", n, 32'd161);
    tick();
    chk("hold_rreq_cycles", rreq_cycles, 32'd8);
    chk("hold_nbytes", bytes.size(), 32'd4);
    chk_word(0, 32'hA1B2_C3D4);

    // Address wrap
    clear_logs();
    do_start(32'hFFFF_FFFC, 16'd2);
    wait_done(1000, n);
    chk("wrap_latency", n, 32'd324);
    tick();
    chk("wrap_nreads", rd_q.size(), 32'd2);
    chk_rd(0, 32'hFFFF_FFFC);
    chk_rd(1, 32'h0000_0000);
    chk("wrap_nbytes", bytes.size(), 32'd8);
    chk_word(0, 32'hCAFE_BABE);
    chk_word(1, 32'h0102_0304);

    // Abort during byte 2 (0x34), while its D0=0 is on the line
    clear_logs();
    do_start(32'h1000_0000, 16'd1);
    repeat (86) tick();
    chk("abort_pre_tx", {31'h0, uart_tx_o}, 32'h0);
    dump_en_i = 1'b0;
    tick();
    chk("abort_tx",   {31'h0, uart_tx_o},  32'h1);
    chk("abort_busy", {31'h0, busy_o},     32'h0);
    chk("abort_rreq", {31'h0, rib_rreq_o}, 32'h0);
    dec_flush = 1'b1;
    tick();
    dec_flush = 1'b0;
    repeat (200) tick();
    chk("abort_done_cnt", done_cnt, 32'd0);
    chk("abort_nbytes", bytes.size(), 32'd2);
    dump_en_i = 1'b1;
    tick();
    clear_logs();
    do_start(32'h1000_0008, 16'd1);
    chk("restart_busy", {31'h0, busy_o}, 32'h1);
    wait_done(400, n);
    chk("restart_latency", n, 32'd162);
    tick();
    chk("restart_done_cnt", done_cnt, 32'd1);
    chk("restart_nbytes", bytes.size(), 32'd4);
    chk_word(0, 32'h0F1E_2D3C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
